// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM state encodings and per-digit adjust constants,
// used by both the BCD-to-binary and binary-to-BCD sides.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] ADJ_THRESH    = 4'd8;
  localparam logic [3:0] ADJ_VAL       = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_sub3.sv
// Combinational per-digit correction for reverse double-dabble:
// a digit that picked up a shifted-in weight of 8 really carries 5, so take 3 off.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= ADJ_THRESH) ? (digit - ADJ_VAL) : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (shift right / subtract-three), one bit per cycle.
// Optional macro BCD_DIGIT_CHECK_EN flags digits above 9 via bcd_err and forces a zero result.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              binary_out,
  output logic                          bcd_err
);

  localparam int SR_W  = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SR_W - 1);

  generate
    if ((2 ** BIN_W) <= (10 ** DIGITS - 1)) begin : g_bin_w_check
      $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [SR_W-1:0]  bcd_reg, bcd_next;
  logic [SR_W-1:0]  bin_reg, bin_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BIN_W-1:0] binary_out_reg, binary_out_next;

  logic [SR_W-1:0]  bcd_shr, bcd_adj, bin_shr;
  logic [BIN_W-1:0] result, result_final;
  logic             start_acc, last_shift;

  // One combined right shift of {bcd_reg, bin_reg}, then per-digit correction
  assign bcd_shr = bcd_reg >> 1;
  assign bin_shr = {bcd_reg[0], bin_reg[SR_W-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
        .digit    (bcd_shr[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .adjusted (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end

    // After the last shift the whole value sits right-aligned in bin_shr
    if (BIN_W <= SR_W) begin : g_res_trunc
      assign result = bin_shr[BIN_W-1:0];
    end else begin : g_res_ext
      assign result = {{(BIN_W - SR_W){1'b0}}, bin_shr};
    end
  endgenerate

`ifdef BCD_DIGIT_CHECK_EN
  logic [DIGITS-1:0] digit_bad;
  logic              err_pend_reg;
  logic              bcd_err_reg;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_check
      assign digit_bad[gi] = (bcd_in[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend_reg <= 1'b0;
      bcd_err_reg  <= 1'b0;
    end else if (start_acc) begin
      err_pend_reg <= |digit_bad;
      bcd_err_reg  <= 1'b0;
    end else if (last_shift) begin
      bcd_err_reg  <= err_pend_reg;
    end
  end

  assign result_final = err_pend_reg ? '0 : result;
  assign bcd_err      = bcd_err_reg;
`else
  assign result_final = result;
  assign bcd_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      bcd_reg        <= '0;
      bin_reg        <= '0;
      cnt_reg        <= '0;
      binary_out_reg <= '0;
    end else begin
      state_reg      <= state_next;
      bcd_reg        <= bcd_next;
      bin_reg        <= bin_next;
      cnt_reg        <= cnt_next;
      binary_out_reg <= binary_out_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bcd_next        = bcd_reg;
    bin_next        = bin_reg;
    cnt_next        = cnt_reg;
    binary_out_next = binary_out_reg;
    start_acc       = 1'b0;
    last_shift      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          bcd_next   = bcd_in;
          bin_next   = '0;
          cnt_next   = '0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_next = bcd_adj;
        bin_next = bin_shr;
        cnt_next = cnt_reg + 1'b1;
        // Result is registered on the final shift so it is valid alongside done
        if (cnt_reg == LAST_CNT) begin
          last_shift      = 1'b1;
          binary_out_next = result_final;
          state_next      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state_reg == ST_SHIFT);
  assign done       = (state_reg == ST_DONE);
  assign binary_out = binary_out_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: vector table, corner sequences,
// random and exhaustive conversions against a decimal reference model.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int EXP_LAT = 4 * DIGITS + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       bcd_in = '0;
  logic              busy, done, bcd_err;
  logic [BIN_W-1:0]  binary_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0] bcd;
    int          exp_val;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .done       (done),
    .binary_out (binary_out),
    .bcd_err    (bcd_err)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Decimal value of the packed digits, independent of any shifting scheme
  function automatic int model_val(input logic [11:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic bit has_bad_digit(input logic [11:0] b);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] b;
    b[3:0]  = 4'(n % 10);
    b[7:4]  = 4'((n / 10) % 10);
    b[11:8] = 4'((n / 100) % 10);
    return b;
  endfunction

  // Pulse start, then sample each cycle on the falling edge until done (bounded)
  task automatic convert(input logic [11:0] b, input int inj_cycle, input logic [11:0] inj_bcd,
                         output int lat, output logic [BIN_W-1:0] res, output logic err,
                         output int busy_cnt);
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = ~b;
    lat = 0;
    busy_cnt = 0;
    res = '0;
    err = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (k == inj_cycle) begin
        start  = 1'b1;
        bcd_in = inj_bcd;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        res = binary_out;
        err = bcd_err;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic do_conv(input string name, input logic [11:0] b, input int exp_val,
                         input bit exp_err, input int inj_cycle, input logic [11:0] inj_bcd);
    int lat, busy_cnt;
    logic [BIN_W-1:0] res;
    logic err;
    convert(b, inj_cycle, inj_bcd, lat, res, err, busy_cnt);
    $display("[TB] %s bcd=%03h out=%0d err=%0b lat=%0d busy=%0d", name, b, res, err, lat, busy_cnt);
    check({name, " latency"}, lat, EXP_LAT);
    check({name, " busy cycles"}, busy_cnt, EXP_LAT - 1);
    check({name, " value"}, res, exp_val);
    check({name, " bcd_err"}, err, exp_err);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int n_done;
    logic [11:0] rb;

    vecs.push_back(vec_t'{12'h999, 999, 1'b0});
    vecs.push_back(vec_t'{12'h000,   0, 1'b0});
    vecs.push_back(vec_t'{12'h255, 255, 1'b0});
    vecs.push_back(vec_t'{12'h123, 123, 1'b0});
    vecs.push_back(vec_t'{12'h042,  42, 1'b0});
    vecs.push_back(vec_t'{12'h500, 500, 1'b0});
    vecs.push_back(vec_t'{12'h001,   1, 1'b0});
    vecs.push_back(vec_t'{12'h909, 909, 1'b0});
`ifdef BCD_DIGIT_CHECK_EN
    vecs.push_back(vec_t'{12'h1A3,   0, 1'b1});
    vecs.push_back(vec_t'{12'h042,  42, 1'b0});
    vecs.push_back(vec_t'{12'hFFF,   0, 1'b1});
    vecs.push_back(vec_t'{12'h99A,   0, 1'b1});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset binary_out", binary_out, 0);
    check("reset bcd_err", bcd_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, applied back-to-back
    foreach (vecs[i]) do_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_val, vecs[i].exp_err, 0, 12'h000);

    // Start ignored while busy
    do_conv("ignored_start", 12'h123, 123, 1'b0, 5, 12'h777);
    count_dones(16, n_done);
    $display("[TB] extra done pulses after ignored start: %0d", n_done);
    check("ignored_start extra done", n_done, 0);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    bcd_in = 12'h456;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] mid reset busy=%0b done=%0b out=%0d err=%0b", busy, done, binary_out, bcd_err);
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset binary_out", binary_out, 0);
    check("mid reset bcd_err", bcd_err, 0);
    count_dones(3, n_done);
    rst_n = 1'b1;
    begin
      int n2;
      count_dones(16, n2);
      n_done += n2;
    end
    check("mid reset no done", n_done, 0);
    do_conv("after_reset", 12'h456, 456, 1'b0, 0, 12'h000);

    // Randomized conversions against the decimal model
    for (int r = 0; r < 200; r++) begin
`ifdef BCD_DIGIT_CHECK_EN
      rb = {4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0))};
`else
      rb = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
`endif
      if (has_bad_digit(rb))
        do_conv($sformatf("rand%0d", r), rb, 0, 1'b1, 0, 12'h000);
      else
        do_conv($sformatf("rand%0d", r), rb, model_val(rb), 1'b0, 0, 12'h000);
    end

    // Exhaustive sweep of valid inputs
    for (int n = 0; n < 1000; n++) do_conv($sformatf("sweep%0d", n), to_bcd(n), n, 1'b0, 0, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
